// File: rtl/instr_pkg.sv
// Shared definitions for the 8-bit core's instruction format and the host-side loader.
package instr_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 0;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DATA,
        CHECK
    } load_state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_COUNT = 2'b01;
    localparam logic [1:0] ERR_CHK   = 2'b10;
    localparam logic [1:0] ERR_RSV   = 2'b11;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;

    function automatic logic is_rsv(input logic [7:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OP_RSV;
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Validates a framed host byte stream (HDR, N, N instructions, CHK), writes the
// instructions into instruction memory and releases the core only after a clean frame.
module instr_loader
    import instr_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter int         AW    = 2,
    parameter logic [7:0] HDR   = HDR_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          mem_busy,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic          core_run,
    output logic          load_done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    load_state_t   state, state_next;
    logic          ready_en;
    logic [AW-1:0] idx, idx_next;
    logic [AW-1:0] last, last_next;
    logic [7:0]    sum, sum_next;
    logic          rsv, rsv_next;
    logic          we_next;
    logic [AW-1:0] waddr_next;
    logic [7:0]    wdata_next;
    logic          run_next, done_next, err_next;
    logic [1:0]    code_next;
    logic          accept;

    // ready_en keeps in_ready low until the first edge after reset release
    assign in_ready = ready_en && !mem_busy;
    assign accept   = in_valid && in_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_next = state;
        idx_next   = idx;
        last_next  = last;
        sum_next   = sum;
        rsv_next   = rsv;
        we_next    = 1'b0;
        waddr_next = mem_waddr;
        wdata_next = mem_wdata;
        run_next   = core_run;
        done_next  = 1'b0;
        err_next   = err;
        code_next  = err_code;
        if (accept) begin
            unique case (state)
                IDLE: begin
                    if (in_data == HDR) begin
                        state_next = COUNT;
                        err_next   = 1'b0;
                        code_next  = ERR_NONE;
                        run_next   = 1'b0;
                        idx_next   = '0;
                        sum_next   = '0;
                        rsv_next   = 1'b0;
                    end
                end
                COUNT: begin
                    if (in_data == 8'd0 || in_data > DEPTH_B) begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                        code_next  = ERR_COUNT;
                    end else begin
                        state_next = DATA;
                        last_next  = AW'(in_data - 8'd1);
                        sum_next   = in_data;
                    end
                end
                DATA: begin
                    we_next    = 1'b1;
                    waddr_next = idx;
                    wdata_next = in_data;
                    sum_next   = sum + in_data;
                    rsv_next   = rsv | is_rsv(in_data);
                    idx_next   = idx + 1'b1;
                    if (idx == last) state_next = CHECK;
                end
                CHECK: begin
                    state_next = IDLE;
                    if (in_data != sum) begin
                        err_next  = 1'b1;
                        code_next = ERR_CHK;
                    end else if (rsv) begin
                        err_next  = 1'b1;
                        code_next = ERR_RSV;
                    end else begin
                        done_next = 1'b1;
                        run_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state     <= IDLE;
            ready_en  <= 1'b0;
            idx       <= '0;
            last      <= '0;
            sum       <= '0;
            rsv       <= 1'b0;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            core_run  <= 1'b0;
            load_done <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            state     <= state_next;
            ready_en  <= 1'b1;
            idx       <= idx_next;
            last      <= last_next;
            sum       <= sum_next;
            rsv       <= rsv_next;
            mem_we    <= we_next;
            mem_waddr <= waddr_next;
            mem_wdata <= wdata_next;
            core_run  <= run_next;
            load_done <= done_next;
            err       <= err_next;
            err_code  <= code_next;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: a frame-level reference model checked every cycle,
// plus literal expectations on the resulting memory image and outcome per scenario.
module tb_instr_loader;

    localparam int         DEPTH = 4;
    localparam logic [7:0] HDR   = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_busy;
    logic       mem_we;
    logic [1:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       core_run;
    logic       load_done;
    logic       err;
    logic [1:0] err_code;
    logic       busy;

    instr_loader #(.DEPTH(DEPTH), .AW(2), .HDR(HDR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_busy  (mem_busy),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .core_run  (core_run),
        .load_done (load_done),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the current frame as a byte list and judges it by the frame rules.
    logic [7:0] fb[$];
    bit         m_ready = 0;
    bit         m_we = 0, m_run = 0, m_done = 0, m_err = 0;
    logic [1:0] m_waddr = '0;
    logic [7:0] m_wdata = '0;
    logic [1:0] m_code = '0;

    task automatic model_byte(input logic [7:0] b);
        int n;
        int s;
        bit r;
        if (fb.size() == 0) begin
            if (b == HDR) begin
                fb.push_back(b);
                m_err = 0;
                m_code = 2'b00;
                m_run = 0;
            end
        end else begin
            fb.push_back(b);
            n = int'(fb[1]);
            if (fb.size() == 2) begin
                if (n == 0 || n > DEPTH) begin
                    m_err = 1;
                    m_code = 2'b01;
                    fb.delete();
                end
            end else if (fb.size() <= n + 2) begin
                m_we = 1;
                m_waddr = 2'(fb.size() - 3);
                m_wdata = b;
            end else begin
                s = n;
                r = 0;
                for (int i = 2; i < n + 2; i++) begin
                    s += int'(fb[i]);
                    if (fb[i][7:6] == 2'b11) r = 1;
                end
                if (b != 8'(s)) begin
                    m_err = 1;
                    m_code = 2'b10;
                end else if (r) begin
                    m_err = 1;
                    m_code = 2'b11;
                end else begin
                    m_done = 1;
                    m_run = 1;
                end
                fb.delete();
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            fb.delete();
            m_ready = 0;
            m_we = 0;
            m_waddr = '0;
            m_wdata = '0;
            m_run = 0;
            m_done = 0;
            m_err = 0;
            m_code = '0;
        end else begin
            bit acc;
            acc = in_valid && m_ready && !mem_busy;
            m_ready = 1;
            m_we = 0;
            m_done = 0;
            if (acc) model_byte(in_data);
        end
    end

    // Memory image and outcome tallies as seen on the DUT's write port.
    logic [7:0] img[4];
    int wr_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_mem_we", mem_we, 0);
            check("rst_mem_waddr", mem_waddr, 0);
            check("rst_mem_wdata", mem_wdata, 0);
            check("rst_core_run", core_run, 0);
            check("rst_load_done", load_done, 0);
            check("rst_err", err, 0);
            check("rst_err_code", err_code, 0);
            check("rst_busy", busy, 0);
        end else begin
            check("in_ready", in_ready, m_ready && !mem_busy);
            check("mem_we", mem_we, m_we);
            check("mem_waddr", mem_waddr, m_waddr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("core_run", core_run, m_run);
            check("load_done", load_done, m_done);
            check("err", err, m_err);
            check("err_code", err_code, m_code);
            check("busy", busy, fb.size() != 0);
            if (mem_we) begin
                img[mem_waddr] = mem_wdata;
                wr_cnt++;
            end
            if (load_done) done_cnt++;
        end
    end

    // Drive one byte and hold it until the handshake completes (bounded).
    task automatic send(input logic [7:0] b);
        bit got = 0;
        bit rdy;
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #2;
            if (rdy) got = 1;
        end
        check("accept_timeout", got, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic nominal();
        send(8'hA5); send(8'h03); send(8'h0A); send(8'h59); send(8'hA3); send(8'h09);
    endtask

    int d0, w0;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        mem_busy = 1'b0;
        for (int i = 0; i < 4; i++) img[i] = 8'h00;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Nominal load
        nominal();
        idle(2);
        check("nom_img0", img[0], 8'h0A);
        check("nom_img1", img[1], 8'h59);
        check("nom_img2", img[2], 8'hA3);
        check("nom_writes", wr_cnt, 3);
        check("nom_done_cnt", done_cnt, 1);
        check("nom_core_run", core_run, 1);
        check("nom_err", err, 0);

        // Checksum mismatch
        img[0] = 8'h00;
        send(8'hA5); send(8'h01); send(8'h0A); send(8'h00);
        idle(2);
        check("chk_img0", img[0], 8'h0A);
        check("chk_err", err, 1);
        check("chk_code", err_code, 2'b10);
        check("chk_core_run", core_run, 0);
        check("chk_done_cnt", done_cnt, 1);

        // Bad counts, then a good frame
        w0 = wr_cnt;
        send(8'hA5); send(8'h00);
        idle(1);
        check("cnt0_code", err_code, 2'b01);
        check("cnt0_busy", busy, 0);
        send(8'hA5); send(8'h05);
        idle(1);
        check("cnt5_code", err_code, 2'b01);
        check("cnt_no_writes", wr_cnt, w0);
        send(8'hA5); send(8'h01); send(8'h0A); send(8'h0B);
        idle(2);
        check("good_err", err, 0);
        check("good_core_run", core_run, 1);
        check("good_done_cnt", done_cnt, 2);

        // Reserved opcode with correct checksum
        send(8'hA5); send(8'h01); send(8'hC1); send(8'hC2);
        idle(2);
        check("rsv_img0", img[0], 8'hC1);
        check("rsv_code", err_code, 2'b11);
        check("rsv_core_run", core_run, 0);

        // Garbage before header, backpressure mid-DATA
        d0 = done_cnt;
        send(8'h00); send(8'hFF);
        send(8'hA5); send(8'h03); send(8'h0A);
        mem_busy = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h59;
        w0 = wr_cnt;
        idle(3);
        check("bp_no_writes", wr_cnt, w0 + 1);
        mem_busy = 1'b0;
        send(8'h59); send(8'hA3); send(8'h09);
        idle(2);
        check("bp_img0", img[0], 8'h0A);
        check("bp_img1", img[1], 8'h59);
        check("bp_img2", img[2], 8'hA3);
        check("bp_done_cnt", done_cnt, d0 + 1);
        check("bp_core_run", core_run, 1);
        check("bp_err", err, 0);

        // Reset mid-frame, right after the second data byte is accepted
        w0 = wr_cnt;
        send(8'hA5); send(8'h03); send(8'h0A); send(8'h59);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_core_run", core_run, 0);
        check("mid_rst_writes", wr_cnt, w0 + 1);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        d0 = done_cnt;
        nominal();
        idle(2);
        check("post_rst_img0", img[0], 8'h0A);
        check("post_rst_img2", img[2], 8'hA3);
        check("post_rst_done", done_cnt, d0 + 1);
        check("post_rst_core_run", core_run, 1);
        check("post_rst_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Host-side writer for the 8-bit core's instruction memory.
- Accepts a framed byte stream on a valid/ready interface and validates it.
- Writes the instructions into the instruction memory write port.
- Holds the core stopped while loading and releases it with `core_run` only after a clean frame.
- Sits between the host/debug link and the instruction memory that the pipeline fetches from.

Parameters:
DEPTH, 4, number of instruction memory words; legal frame count is 1..DEPTH
AW, 2, address width of the memory write port; DEPTH <= 2**AW
HDR, 8'hA5, frame header byte

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  host byte valid
in_data  input  8  host byte
in_ready  output  1  loader accepts byte; transfer occurs when in_valid && in_ready on a rising edge
mem_busy  input  1  memory write port unavailable; forces in_ready low
mem_we  output  1  instruction memory write enable
mem_waddr  output  AW  instruction memory write address
mem_wdata  output  8  instruction word; format [7:6] opcode, [5:3] rd, [2:0] rs
core_run  output  1  core fetch enable / release
load_done  output  1  one-cycle pulse on successful frame
err  output  1  sticky error flag
err_code  output  2  00 none, 01 bad count, 10 checksum mismatch, 11 reserved opcode present
busy  output  1  frame in progress (state not IDLE)

Behaviour:
- Reset (async assert, sync release) sets outputs and state:
  - in_ready=0 while rst_n low, and 1 from the first edge after release when mem_busy=0.
  - mem_we=0, mem_waddr=0, mem_wdata=0, core_run=0, load_done=0, err=0, err_code=00, busy=0.
  - State goes to IDLE.
- in_ready = !mem_busy in every state. No byte is ever dropped once accepted, except in IDLE as described below.
- Frame format: HDR, N, N instruction bytes, CHK. CHK = (N + sum of instruction bytes) mod 256.
- States:
  - IDLE: accepted byte == HDR -> COUNT. Also on that accept:
    - clear err/err_code;
    - drop core_run to 0 on the next cycle;
    - reset the index and the running sum.
  - IDLE: any other byte is discarded; stay in IDLE.
  - COUNT: accepted N.
    - N==0 or N>DEPTH -> IDLE with err=1, err_code=01.
    - Otherwise store N, sum=N -> DATA.
  - DATA: each accepted byte b at index k:
    - next cycle: mem_we=1, mem_waddr=k, mem_wdata=b;
    - sum += b (8-bit wrap);
    - set the internal rsv flag if b[7:6]==2'b11;
    - k==N-1 -> CHECK.
  - CHECK: accepted byte c, go to IDLE. Outcome, in priority order:
    - c != sum: err=1, err_code=10.
    - else rsv set: err=1, err_code=11.
    - else: load_done pulses 1 cycle and core_run=1, both on the cycle after the accept.
- mem_we is high for exactly one cycle per accepted data byte. Latency from accept to write is 1 cycle. Gaps from in_valid=0 or mem_busy=1 insert idle cycles with mem_we=0.
- mem_waddr and mem_wdata hold their last values when mem_we=0.
- core_run:
  - stays 1 until the next accepted HDR; stays 0 after any error;
  - is never 1 while busy=1.
- A partial memory image after an error is left as written; core_run=0 prevents execution of it.
- An HDR byte received inside DATA is treated as data (no resync). Resync happens only from IDLE.
- err and err_code are sticky until the next accepted HDR or reset.
- Reset asserted mid-frame: immediate return to IDLE, core_run=0, and any pending mem_we is cancelled.
- A write already issued stays in memory.

Decomposition:
- Shared package instr_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_LOAD=2'b10, OP_RSV=2'b11;
  - instruction field slice positions;
  - loader state enum (IDLE, COUNT, DATA, CHECK);
  - err_code constants;
  - HDR default.
- Single module; no sub-module needed. The checksum accumulator is inline.

Test Plan:
- Nominal load: stream A5 03 0A 59 A3 09, mem_busy=0.
  - Writes (0,0A), (1,59), (2,A3) on consecutive cycles.
  - load_done pulse once; core_run=1; err=0.
- Checksum mismatch: A5 01 0A 00.
  - Write (0,0A) occurs; err=1, err_code=10, core_run=0, no load_done.
- Bad count: A5 00, then A5 05 (DEPTH=4).
  - Both -> err_code=01, back to IDLE, no mem_we.
  - A following good frame A5 01 0A 0B clears err and sets core_run=1.
- Reserved opcode: A5 01 C1 C2 (checksum correct).
  - Write (0,C1); err_code=11; core_run=0.
- Backpressure and garbage: leading bytes 00 FF before the header are discarded.
  - During the nominal frame, pulse mem_busy for 3 cycles mid-DATA: in_ready=0, no accepts, no mem_we.
  - Final image and outcome identical to the nominal scenario.
- Reset mid-frame: assert rst_n=0 after the 2nd data byte of the nominal frame.
  - All outputs return to reset values asynchronously.
  - After release, a full nominal frame loads correctly.
